arbitro_serial_tx: RTL and testbench

Shares the single serial transmitter (tx_serial core) among N_REQ byte producers: automatic status sender, command echo, alarm reporter. Round-robin arbitration per byte. A requester holding `lock` keeps ownership across a multi-byte frame so frames are never interleaved. Sits between the sender FSMs and the tx core's start/done handshake.

---
 rtl/arbitro_serial_pkg.sv | 22 ++
 rtl/arbitro_serial_tx_seletor_round_robin.sv | 29 ++
 rtl/arbitro_serial_tx.sv | 135 +++++++++++++
 tb/tb_arbitro_serial_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_serial_pkg.sv
// Shared definitions for the serial transmitter arbiter: FSM encoding,
// default byte width and the owner-index width helper.
package arbitro_serial_pkg;

   // Arbiter FSM states.
   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      ARBITRA = 3'd1,
      PARTIDA = 3'd2,
      ESPERA  = 3'd3,
      CONCLUI = 3'd4,
      SEGURA  = 3'd5
   } estado_t;

   localparam int DATA_W_PADRAO = 8;

   // Owner index width: max(1, clog2(n)).
   function automatic int largura_indice(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arbitro_serial_tx_seletor_round_robin.sv
// Combinational round-robin selector: the first active request found at
// ptr+1, ptr+2, ... (modulo N_REQ). The last winner is checked last.
module seletor_round_robin #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valido,
   output logic [IDX_W-1:0] indice
);

   int pos;

   // Scan all requesters starting just after the pointer; keep the first hit.
   always_comb begin
      valido = 1'b0;
      indice = '0;
      pos    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = (int'(ptr) + k) % N_REQ;
         if (!valido && req[pos]) begin
            valido = 1'b1;
            indice = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/arbitro_serial_tx.sv
// Shares one serial transmitter among N_REQ byte producers. Round-robin per
// byte; a requester holding lock keeps ownership across a multi-byte frame.
// Optional watchdog: define ARBITRO_SERIAL_TX_TIMEOUT_EN to abort a transfer
// (ESPERA) or a held frame (SEGURA) after TIMEOUT_CICLOS clocks and raise the
// sticky erro_timeout flag.
module arbitro_serial_tx
   import arbitro_serial_pkg::*;
#(
   parameter  int N_REQ          = 3,
   parameter  int DATA_W         = DATA_W_PADRAO,
   parameter  int TIMEOUT_CICLOS = 200000,
   localparam int IDX_W          = largura_indice(N_REQ)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ*DATA_W-1:0] dados_in,
   input  logic                    tx_pronto,
   output logic                    tx_partida,
   output logic [DATA_W-1:0]       tx_dados,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        enviado,
   output logic [IDX_W-1:0]        dono,
   output logic                    erro_timeout
);

   estado_t          estado, prox;
   logic [IDX_W-1:0] ptr;
   logic             valido;
   logic [IDX_W-1:0] indice;
   logic             estouro;
   logic [N_REQ-1:0] dono_onehot;

   seletor_round_robin #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_seletor (
      .req    (req),
      .ptr    (ptr),
      .valido (valido),
      .indice (indice)
   );

   assign dono_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << dono;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox;
   end

   // Next-state logic; in SEGURA a pending byte beats a lock release.
   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  if (|req) prox = ARBITRA;
         ARBITRA: prox = valido ? PARTIDA : OCIOSO;
         PARTIDA: prox = ESPERA;
         ESPERA: begin
            if (tx_pronto)    prox = CONCLUI;
            else if (estouro) prox = OCIOSO;
         end
         CONCLUI: prox = lock[dono] ? SEGURA : OCIOSO;
         SEGURA: begin
            if (req[dono])                   prox = PARTIDA;
            else if (!lock[dono] || estouro) prox = OCIOSO;
         end
         default: prox = OCIOSO;
      endcase
   end

   // Owner, pointer and byte latch; ptr moves only on a completed byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr      <= IDX_W'(N_REQ-1);
         dono     <= '0;
         tx_dados <= '0;
      end else begin
         case (estado)
            ARBITRA: begin
               if (valido) begin
                  dono     <= indice;
                  tx_dados <= dados_in[int'(indice)*DATA_W +: DATA_W];
               end
            end
            CONCLUI: ptr <= dono;
            SEGURA: begin
               if (req[dono]) tx_dados <= dados_in[int'(dono)*DATA_W +: DATA_W];
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the state and the latched owner.
   always_comb begin
      tx_partida = (estado == PARTIDA);
      grant      = '0;
      enviado    = '0;
      if (estado == PARTIDA || estado == ESPERA ||
          estado == CONCLUI || estado == SEGURA)
         grant = dono_onehot;
      if (estado == CONCLUI)
         enviado = dono_onehot;
   end

`ifdef ARBITRO_SERIAL_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);

   logic [CNT_W-1:0] contador;
   logic             erro_r;

   assign estouro = (estado == ESPERA || estado == SEGURA) &&
                    (contador == CNT_W'(TIMEOUT_CICLOS - 1));
   assign erro_timeout = erro_r;

   // Watchdog counter: restarts on every state change, counts while waiting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                        contador <= '0;
      else if (prox != estado)                          contador <= '0;
      else if (estado == ESPERA || estado == SEGURA)    contador <= contador + 1'b1;
   end

   // Sticky error flag, raised only when the watchdog actually aborts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                            erro_r <= 1'b0;
      else if (estouro && prox == OCIOSO)   erro_r <= 1'b1;
   end
`else
   assign estouro      = 1'b0;
   assign erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_serial_tx.sv
// Scoreboard bench for arbitro_serial_tx: requester agents replay byte frames,
// a tx core model answers tx_partida with tx_pronto, and a round-robin model
// over whole frames predicts the service order.
module tb_arbitro_serial_tx;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int TO = 64;
   localparam int IW = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req, lock;
   logic [N*W-1:0]   dados_in;
   logic             tx_pronto;
   logic             tx_partida;
   logic [W-1:0]     tx_dados;
   logic [N-1:0]     grant, enviado;
   logic [IW-1:0]    dono;
   logic             erro_timeout;

   always #5 clock = ~clock;

   arbitro_serial_tx #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CICLOS(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .lock(lock), .dados_in(dados_in),
      .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dados(tx_dados),
      .grant(grant), .enviado(enviado), .dono(dono), .erro_timeout(erro_timeout)
   );

   int nchk = 0, npass = 0;

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
   endtask

   // Frame memory shared with the agents: per requester a byte list and a
   // "more bytes follow in this frame" bit per byte.
   logic [W-1:0] mem_b [N][32];
   bit           mem_l [N][32];
   int           cnt [N];
   int           pos [N];
   int           ld_gen = 0, ld_seen = 0;

   typedef struct { int who; logic [W-1:0] b; } exp_t;
   exp_t exp_q[$];
   int   ptr_m;

   int   tx_en = 1, rnd_dly = 0, dly_fix = 20;
   int   spur_cnt = 0, spur_done = 0;
   bit   tx_busy;
   int   dly;

   task automatic clr();
      for (int i = 0; i < N; i++) cnt[i] = 0;
   endtask

   task automatic add_frame(input int i, input int len, input logic [W-1:0] base, input bit rnd);
      for (int j = 0; j < len; j++) begin
         mem_b[i][cnt[i]] = rnd ? W'($urandom) : base + W'(j);
         mem_l[i][cnt[i]] = (j != len - 1);
         cnt[i]++;
      end
   endtask

   // Expected order: whole frames, round-robin after the last winner.
   task automatic plan();
      int p[N];
      int found;
      bit last;
      for (int i = 0; i < N; i++) p[i] = 0;
      forever begin
         found = -1;
         for (int k = 1; k <= N; k++)
            if (found < 0 && p[(ptr_m + k) % N] < cnt[(ptr_m + k) % N]) found = (ptr_m + k) % N;
         if (found < 0) break;
         last = 1'b0;
         while (!last && p[found] < cnt[found]) begin
            exp_q.push_back('{who: found, b: mem_b[found][p[found]]});
            last = !mem_l[found][p[found]];
            p[found]++;
         end
         ptr_m = found;
      end
      ld_gen++;
   endtask

   task automatic step();
      @(posedge clock); #2;
   endtask

   function automatic bit agents_done();
      for (int i = 0; i < N; i++) if (pos[i] < cnt[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input int budget);
      int t = 0;
      while (t < budget && !(exp_q.size() == 0 && agents_done() && grant == 0 && !tx_busy)) begin
         step(); t++;
      end
      chk("idle_within_budget", 32'(t < budget), 1);
   endtask

   // Requester agents: hold req with the current byte, advance the cycle
   // after enviado, drop req when the list is exhausted.
   initial begin
      logic [N-1:0] env_d;
      req = '0; lock = '0; dados_in = '0; env_d = '0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; pos[i] = 0; end
      forever begin
         @(posedge clock); #1;
         if (ld_gen != ld_seen) begin
            ld_seen = ld_gen;
            for (int i = 0; i < N; i++) pos[i] = 0;
            env_d = '0;
         end
         for (int i = 0; i < N; i++) begin
            if (env_d[i] && pos[i] < cnt[i]) pos[i]++;
            if (pos[i] < cnt[i]) begin
               req[i] = 1'b1;
               lock[i] = mem_l[i][pos[i]];
               dados_in[i*W +: W] = mem_b[i][pos[i]];
            end else begin
               req[i] = 1'b0;
               lock[i] = 1'b0;
            end
         end
         env_d = enviado;
      end
   end

   // tx core model: pulses tx_pronto a programmable time after tx_partida.
   initial begin
      tx_pronto = 1'b0; tx_busy = 1'b0; dly = 0;
      forever begin
         @(posedge clock); #1;
         tx_pronto = 1'b0;
         if (reset) tx_busy = 1'b0;
         else begin
            if (tx_busy) begin
               if (dly == 0) begin tx_pronto = 1'b1; tx_busy = 1'b0; end
               else dly--;
            end
            if (tx_partida && tx_en != 0) begin
               chk("partida_while_busy", 32'(tx_busy), 0);
               tx_busy = 1'b1;
               dly = (rnd_dly != 0) ? int'($urandom_range(0, 7)) : dly_fix - 1;
            end
            if (spur_cnt != spur_done) begin tx_pronto = 1'b1; spur_done++; end
         end
      end
   end

   // Monitor: pops the scoreboard on every tx_partida.
   initial begin
      exp_t e;
      int   last_own = 0;
      logic [W-1:0] cur_b = '0;
      forever begin
         @(posedge clock); #1;
         if (!reset) begin
            if (tx_partida) begin
               if (exp_q.size() == 0) chk("unexpected_partida", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("dono", 32'(dono), 32'(e.who));
                  chk("grant", 32'(grant), 32'(1) << e.who);
                  chk("tx_dados", 32'(tx_dados), 32'(e.b));
                  last_own = e.who;
                  cur_b = e.b;
               end
            end else if (grant != 0) begin
               chk("tx_dados_stable", 32'(tx_dados), 32'(cur_b));
            end
            if (enviado != 0) chk("enviado_owner", 32'(enviado), 32'(1) << last_own);
         end
      end
   end

   task automatic latency_check(input logic [W-1:0] b);
      step();
      chk("c0_grant", 32'(grant), 0);
      chk("c0_partida", 32'(tx_partida), 0);
      step();
      chk("c1_partida", 32'(tx_partida), 0);
      step();
      chk("c2_partida", 32'(tx_partida), 1);
      chk("c2_grant", 32'(grant), 1);
      chk("c2_dados", 32'(tx_dados), 32'(b));
   endtask

   initial begin
      int k, t, bad, n_env, n_err;
      ptr_m = N - 1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_partida", 32'(tx_partida), 0);
      chk("rst_dados", 32'(tx_dados), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_enviado", 32'(enviado), 0);
      chk("rst_dono", 32'(dono), 0);
      chk("rst_erro", 32'(erro_timeout), 0);
      reset = 1'b0;

      // Single byte from requester 0, tx_pronto 20 cycles after partida.
      @(negedge clock); clr(); add_frame(0, 1, 8'h41, 0); plan();
      latency_check(8'h41);
      k = 0;
      while (enviado == 0 && k < 50) begin step(); k++; end
      chk("enviado_delay", 32'(k), 21);
      chk("enviado_vec", 32'(enviado), 1);
      step();
      chk("enviado_one_cycle", 32'(enviado), 0);
      chk("grant_released", 32'(grant), 0);
      wait_idle(100);

      // Locked 3-byte frame from req1 while req0 waits.
      dly_fix = 4;
      @(negedge clock); clr(); add_frame(1, 3, 8'hA0, 0); add_frame(0, 1, 8'h30, 0); plan();
      t = 0;
      while (grant == 0 && t < 20) begin step(); t++; end
      bad = 0; n_env = 0;
      while (n_env < 3 && t < 200) begin
         if (grant != 3'b010) bad++;
         if (enviado != 0) n_env++;
         step(); t++;
      end
      chk("lock_grant_held", 32'(bad), 0);
      chk("lock_bytes", 32'(n_env), 3);
      wait_idle(200);

      // From reset: req0 and req2 alternate.
      @(negedge clock); reset = 1'b1; ptr_m = N - 1;
      @(negedge clock); reset = 1'b0;
      rnd_dly = 1;
      @(negedge clock); clr();
      for (int j = 0; j < 3; j++) begin add_frame(0, 1, 0, 1); add_frame(2, 1, 0, 1); end
      plan();
      wait_idle(400);

      // All three continuously: 0,1,2,0,1,2 with pointer wrap.
      @(negedge clock); clr();
      for (int j = 0; j < 2; j++) for (int i = 0; i < N; i++) add_frame(i, 1, 0, 1);
      plan();
      wait_idle(400);

      // Random frame mixes.
      repeat (8) begin
         @(negedge clock); clr();
         for (int i = 0; i < N; i++) begin
            int nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) add_frame(i, int'($urandom_range(1, 3)), 0, 1);
         end
         plan();
         wait_idle(1500);
      end

      // tx_pronto while idle is ignored.
      @(negedge clock); spur_cnt++;
      bad = 0;
      repeat (4) begin step(); if (enviado != 0 || grant != 0) bad++; end
      chk("spurious_pronto", 32'(bad), 0);

      // No tx_pronto after partida.
      tx_en = 0; rnd_dly = 0; dly_fix = 3;
      @(negedge clock); clr(); add_frame(0, 1, 8'hC3, 0); plan();
      t = 0;
      while (!tx_partida && t < 20) begin step(); t++; end
      chk("hang_partida_seen", 32'(tx_partida), 1);
`ifdef ARBITRO_SERIAL_TX_TIMEOUT_EN
      exp_q.push_back('{who: 0, b: 8'hC3});
      t = 0; n_env = 0;
      while (!erro_timeout && t < TO + 20) begin step(); t++; if (enviado != 0) n_env++; end
      chk("timeout_cycles", 32'(t), TO + 1);
      chk("timeout_no_enviado", 32'(n_env), 0);
      chk("timeout_grant", 32'(grant), 0);
      tx_en = 1;
      wait_idle(200);
      chk("timeout_sticky", 32'(erro_timeout), 1);
      tx_en = 0;
      @(negedge clock); clr(); add_frame(0, 1, 8'h77, 0); plan();
      t = 0;
      while (!tx_partida && t < 20) begin step(); t++; end
      repeat (5) step();
`else
      n_env = 0; n_err = 0;
      repeat (3 * TO) begin step(); if (enviado != 0) n_env++; if (erro_timeout) n_err++; end
      chk("hang_no_enviado", 32'(n_env), 0);
      chk("hang_no_erro", 32'(n_err), 0);
      chk("hang_grant_held", 32'(grant), 1);
`endif

      // Reset during ESPERA.
      @(negedge clock); reset = 1'b1; #1;
      chk("midrst_partida", 32'(tx_partida), 0);
      chk("midrst_dados", 32'(tx_dados), 0);
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_enviado", 32'(enviado), 0);
      chk("midrst_dono", 32'(dono), 0);
      chk("midrst_erro", 32'(erro_timeout), 0);
      clr(); ld_gen++; ptr_m = N - 1; tx_en = 1;
      step();
      @(negedge clock); reset = 1'b0;
      @(negedge clock); clr(); add_frame(0, 1, 8'h5A, 0); plan();
      latency_check(8'h5A);
      wait_idle(100);

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
